// File: rtl/data_memory_responder.sv
// SRAM-window bus responder: decodes the data-memory window, serves reads onto the shared
// bus_data line, commits one write per strobe. Optional wait states via MEM_WAIT_STATES_EN.
module data_memory_responder #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 16'h0040,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 16'h00BF,
  parameter int                    WAIT_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  mem_cs,
  input  logic                  mem_we,
  input  logic                  mem_oe,
  output logic                  mem_ready,
  output logic                  access_error
);

  localparam int DEPTH = int'(MEM_STOP_ADDR) - int'(MEM_START_ADDR) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WDONE
`ifdef MEM_WAIT_STATES_EN
    , S_WAIT
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic                   mem_wr;
  logic                   in_win, hit;
  logic [IDX_W-1:0]       idx;

`ifdef MEM_WAIT_STATES_EN
  logic [3:0] cnt_q, cnt_d;
  logic       is_wr_q, is_wr_d;
`endif

  assign in_win = (bus_addr >= MEM_START_ADDR) && (bus_addr <= MEM_STOP_ADDR);
  assign hit    = mem_cs && in_win;
  assign idx    = IDX_W'(bus_addr - MEM_START_ADDR);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_wr  = 1'b0;
`ifdef MEM_WAIT_STATES_EN
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Illegal requests are rejected before any decode so they never touch the array.
        if (mem_cs && mem_we && mem_oe) begin
          err_d = 1'b1;
        end else if (mem_cs && !in_win && (mem_we || mem_oe)) begin
          err_d = 1'b1;
        end else if (hit && mem_oe) begin
`ifdef MEM_WAIT_STATES_EN
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          is_wr_d = 1'b0;
`else
          rdata_d = mem_q[idx];
          state_d = S_READ;
`endif
        end else if (hit && mem_we) begin
`ifdef MEM_WAIT_STATES_EN
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          is_wr_d = 1'b1;
`else
          mem_wr  = 1'b1;
          state_d = S_WDONE;
`endif
        end
      end
      S_READ: begin
        if (!(mem_cs && mem_oe)) state_d = S_IDLE;
        else if (in_win)         rdata_d = mem_q[idx];
      end
      S_WDONE: begin
        if (!(mem_cs && mem_we)) state_d = S_IDLE;
      end
`ifdef MEM_WAIT_STATES_EN
      S_WAIT: begin
        if (is_wr_q ? !(mem_cs && mem_we) : !(mem_cs && mem_oe)) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          if (is_wr_q) begin
            mem_wr  = in_win;
            state_d = S_WDONE;
          end else begin
            rdata_d = mem_q[idx];
            state_d = S_READ;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_WAIT_STATES_EN
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
`endif
    end
  end

  // Array is deliberately not reset; reset only suppresses a write in flight.
  always_ff @(posedge clk) begin
    if (mem_wr && !reset) mem_q[idx] <= bus_data;
  end

  assign bus_data     = (state_q == S_READ && mem_cs && mem_oe) ? rdata_q : 'z;
  assign access_error = err_q;

`ifdef MEM_WAIT_STATES_EN
  assign mem_ready = (state_q != S_WAIT);
`else
  assign mem_ready = 1'b1;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed + randomized bench for data_memory_responder against an address-keyed memory model.
// Released bus reads as 0 through pulldowns, so "released" is checked as 8'h00 with nonzero rdata.
module tb_data_memory_responder;
  localparam int          DW    = 8;
  localparam int          AW    = 16;
  localparam logic [15:0] START = 16'h0040;
  localparam logic [15:0] STOP  = 16'h00BF;
  localparam int          WC    = 2;
`ifdef MEM_WAIT_STATES_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] bus_addr = '0;
  logic          mem_cs = 1'b0, mem_we = 1'b0, mem_oe = 1'b0;
  logic          mem_ready, access_error;
  logic [DW-1:0] tb_drv = '0;
  logic          tb_en = 1'b0;
  wire  [DW-1:0] bus_data;

  assign bus_data = tb_en ? tb_drv : 'z;
  for (genvar gi = 0; gi < DW; gi++) begin : g_pd
    pulldown (bus_data[gi]);
  end

  data_memory_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_START_ADDR(START),
    .MEM_STOP_ADDR(STOP), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_ready(mem_ready), .access_error(access_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [logic [15:0]];
  logic [15:0] written [$];
  logic [7:0]  seq_vals [3];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    mem_cs = 1'b0; mem_we = 1'b0; mem_oe = 1'b0; tb_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_ready", 16'(mem_ready), 16'd1);
    check("reset_err", 16'(access_error), 16'd0);
    check("reset_bus", 16'(bus_data), 16'h0);
  endtask

  // Counts edges with mem_ready low after the request edge; bounded.
  task automatic wait_ready(input string tag);
    int lo = 0;
    tick();
    while (!mem_ready && lo < 20) begin lo++; tick(); end
    check(tag, 16'(lo), 16'(EXP_WAIT));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; tb_drv = d; tb_en = 1'b1;
    mem_cs = 1'b1; mem_we = 1'b1; mem_oe = 1'b0;
    wait_ready("wr_wait");
    ref_mem[a] = d;
    written.push_back(a);
    idle_bus();
    tick();
  endtask

  task automatic start_read(input logic [15:0] a);
    bus_addr = a; tb_en = 1'b0;
    mem_cs = 1'b1; mem_oe = 1'b1; mem_we = 1'b0;
    wait_ready("rd_wait");
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    start_read(a);
    check(tag, 16'(bus_data), 16'(ref_mem[a]));
    mem_oe = 1'b0;
    #1;
    check({tag, "_release"}, 16'(bus_data), 16'h0);
    idle_bus();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    do_reset();

    // Window boundaries
    wr(16'h0040, 8'hA5);
    rd(16'h0040, "rd_start");
    wr(16'h00BF, 8'h3C);
    rd(16'h00BF, "rd_stop");

    // Random writes then random readback
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = START + 16'($urandom_range(0, 127));
      wr(a, 8'($urandom_range(1, 255)));
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = written[$urandom_range(0, written.size() - 1)];
      rd(a, "rd_rand");
    end

    // Out-of-window accesses: no drive, sticky error, no aliasing into the array
    bus_addr = 16'h003F; mem_cs = 1'b1; mem_oe = 1'b1;
    tick();
    check("oow_lo_err", 16'(access_error), 16'd1);
    check("oow_lo_bus", 16'(bus_data), 16'h0);
    idle_bus();
    tick();
    check("oow_sticky", 16'(access_error), 16'd1);
    do_reset();
    bus_addr = 16'h00C0; tb_drv = 8'hEE; tb_en = 1'b1; mem_cs = 1'b1; mem_we = 1'b1;
    tick();
    check("oow_hi_err", 16'(access_error), 16'd1);
    idle_bus();
    tick();
    rd(16'h0040, "rd_no_alias");
    check("err_after_good", 16'(access_error), 16'd1);

    // One write per strobe while data changes
    seq_vals[0] = 8'h11; seq_vals[1] = 8'h22; seq_vals[2] = 8'h33;
    bus_addr = 16'h0050; tb_en = 1'b1; mem_cs = 1'b1; mem_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb_drv = seq_vals[i];
      tick();
    end
    idle_bus();
    tick();
    ref_mem[16'h0050] = seq_vals[EXP_WAIT];
    rd(16'h0050, "rd_single_wr");

    // cs+we+oe together: rejected, no write, no drive
    do_reset();
    wr(16'h0060, 8'h77);
    bus_addr = 16'h0060; tb_drv = 8'h99; tb_en = 1'b1;
    mem_cs = 1'b1; mem_we = 1'b1; mem_oe = 1'b1;
    tick();
    check("weoe_err", 16'(access_error), 16'd1);
    tb_en = 1'b0;
    #1;
    check("weoe_bus", 16'(bus_data), 16'h0);
    idle_bus();
    tick();
    rd(16'h0060, "rd_weoe_kept");

    // Address change while reading reloads data
    start_read(16'h0040);
    check("rd_chg_a", 16'(bus_data), 16'(ref_mem[16'h0040]));
    bus_addr = 16'h00BF;
    tick();
    check("rd_chg_b", 16'(bus_data), 16'(ref_mem[16'h00BF]));

    // Reset taken while in READ with strobes still asserted
    reset = 1'b1;
    tick();
    check("rst_rd_bus", 16'(bus_data), 16'h0);
    check("rst_rd_ready", 16'(mem_ready), 16'd1);
    check("rst_rd_err", 16'(access_error), 16'd0);
    reset = 1'b0;
    idle_bus();
    tick();

`ifdef MEM_WAIT_STATES_EN
    // Write aborted during WAIT leaves old contents
    wr(16'h0070, 8'h12);
    bus_addr = 16'h0070; tb_drv = 8'h55; tb_en = 1'b1; mem_cs = 1'b1; mem_we = 1'b1;
    tick();
    check("abort_ready", 16'(mem_ready), 16'd0);
    idle_bus();
    tick();
    check("abort_idle", 16'(mem_ready), 16'd1);
    rd(16'h0070, "rd_abort_kept");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
